// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: symbol stream in, phase-continuous square-wave tones out.
// Tone k toggles every DIV_BASE + k*DIV_STEP clocks; each symbol lasts SYM_LEN clocks.
module mfsk_modulator #(
   parameter int SYM_BITS = 2,
   parameter int DIV_BASE = 2,
   parameter int DIV_STEP = 1,
   parameter int SYM_LEN  = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SYM_BITS-1:0] s_data,
   output logic                fsk_out,
   output logic [SYM_BITS-1:0] tone_idx,
   output logic                busy,
   output logic                sym_strobe
);

   localparam int HP_MAX = DIV_BASE + ((1 << SYM_BITS) - 1) * DIV_STEP;
   localparam int HW = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
   localparam int SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
   localparam logic [SW-1:0] SCNT_LAST = SW'(SYM_LEN - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]          r_state;
   logic [HW-1:0]       r_hcnt;
   logic [SW-1:0]       r_scnt;
   logic                r_fsk;
   logic [SYM_BITS-1:0] r_tone;
   logic                r_strobe;

   logic [31:0] w_hp_m1;
   logic        w_wrap;
   logic        w_last;

   assign w_hp_m1 = 32'(DIV_BASE - 1) + 32'(r_tone) * 32'(DIV_STEP);
   // >= so a long count left over from a slower tone still wraps at once
   assign w_wrap  = 32'(r_hcnt) >= w_hp_m1;
   assign w_last  = (r_scnt == SCNT_LAST);

   assign s_ready    = (r_state == ST_IDLE) | w_last;
   assign busy       = (r_state == ST_SEND);
   assign fsk_out    = r_fsk;
   assign tone_idx   = r_tone;
   assign sym_strobe = r_strobe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_hcnt   <= '0;
         r_scnt   <= '0;
         r_fsk    <= 1'b0;
         r_tone   <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_fsk  <= 1'b0;
            r_hcnt <= '0;
            r_scnt <= '0;
            if (s_valid) begin
               r_state  <= ST_SEND;
               r_tone   <= s_data;
               r_strobe <= 1'b1;
            end
         end else begin
            if (w_wrap) begin
               r_fsk  <= ~r_fsk;
               r_hcnt <= '0;
            end else begin
               r_hcnt <= r_hcnt + HW'(1);
            end
            if (!w_last) begin
               r_scnt <= r_scnt + SW'(1);
            end else if (s_valid) begin
               // back-to-back: tone counter keeps running for phase continuity
               r_tone   <= s_data;
               r_scnt   <= '0;
               r_strobe <= 1'b1;
            end else begin
               r_state <= ST_IDLE;
               r_fsk   <= 1'b0;
               r_hcnt  <= '0;
               r_scnt  <= '0;
            end
         end
      end
   end

endmodule

// File: doc/mfsk_modulator.md
Name: mfsk_modulator

Overview:
Parametrised M-ary FSK modulator, successor to the two-tone FSK transmitter path.
- Takes symbols of SYM_BITS bits over a valid/ready stream.
- Maps each symbol to one of 2^SYM_BITS square-wave tones, all derived internally from clk by programmable half-period counters. External tone inputs are not used.
- Holds each symbol for SYM_LEN clocks and switches tone phase-continuously on back-to-back symbols.
- Feeds the transmitter output stage and loopback demodulator tests.

Parameters:
- SYM_BITS, 2: bits per symbol, 1..3; number of tones = 2^SYM_BITS.
- DIV_BASE, 2: half-period of tone 0 in clk cycles, >=1.
- DIV_STEP, 1: half-period increment per tone index, >=0.
- SYM_LEN, 24: clk cycles per symbol, >=2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  symbol valid.
- s_ready  out  1  symbol accept; transfer occurs when s_valid & s_ready at a rising edge.
- s_data  in  SYM_BITS  symbol value; sampled only on transfer.
- fsk_out  out  1  modulated square wave.
- tone_idx  out  SYM_BITS  symbol currently being transmitted.
- busy  out  1  high while a symbol is being transmitted.
- sym_strobe  out  1  one-cycle pulse in the first cycle of every symbol.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. Both are fixed decisions.
- Reset (asserts immediately, no clock needed): state=IDLE, fsk_out=0, tone_idx=0, busy=0, sym_strobe=0, s_ready=1, hcnt=0, scnt=0.
- Half-period for tone k: hp(k) = DIV_BASE + k*DIV_STEP.
  - hcnt width = clog2 of the max hp, minimum 1.
  - scnt width = clog2(SYM_LEN), minimum 1.
- FSM state IDLE:
  - s_ready=1, busy=0, fsk_out held 0.
  - On transfer → SEND: tone_idx<=s_data, hcnt<=0, scnt<=0, fsk_out<=0, sym_strobe<=1.
- FSM state SEND:
  - busy=1.
  - Each cycle: if hcnt >= hp(tone_idx)-1 then fsk_out<=~fsk_out and hcnt<=0, else hcnt<=hcnt+1.
  - scnt increments each cycle.
  - s_ready is combinationally 1 only when scnt==SYM_LEN-1, 0 otherwise.
- Symbol end (scnt==SYM_LEN-1), transfer occurs:
  - Stay in SEND: tone_idx<=s_data, scnt<=0, sym_strobe<=1.
  - fsk_out and hcnt keep the normal toggle/increment rule; no reset, no gap (phase continuity).
  - The new hp takes effect from the next cycle.
  - The >= compare guarantees a toggle on the first new-symbol cycle if hcnt already exceeds the new hp-1.
- Symbol end, no transfer: → IDLE, fsk_out<=0, hcnt<=0, busy<=0, tone_idx holds its last value.
- sym_strobe: registered, high exactly one cycle after each transfer edge. Deasserted all other cycles.
- Latency and timing:
  - Transfer edge T → busy, tone_idx and sym_strobe valid in cycle T+1.
  - First fsk_out rise hp clocks after T; output period 2*hp.
- s_data must be held stable by the source while s_valid=1 and no transfer has occurred. The block never samples it otherwise.
- No symbol is dropped or duplicated.
- A symbol waiting mid-SEND is accepted only on the last symbol cycle.
- Reset during SEND aborts the current symbol; the pending symbol is not accepted.

Test Plan:
1. rst_n=0 with clk stopped → fsk_out=0, busy=0, s_ready=1, sym_strobe=0, tone_idx=0 immediately; release → stays IDLE with s_valid=0.
2. Single symbol s_data=0, defaults → sym_strobe one cycle after accept; fsk_out toggles every 2 clocks, 6 full periods; busy=1 for exactly 24 cycles; then IDLE, fsk_out=0, s_ready=1.
3. Back-to-back symbols 3 then 1 with s_valid held high → sym_strobes exactly 24 cycles apart.
   - Tone 3: half-period 5; hcnt=4 at the boundary.
   - fsk_out toggles on the first symbol-1 cycle, then every 3 clocks.
   - No return to 0 and no idle cycle at the boundary.
4. s_valid raised at scnt=5 of a running symbol → s_ready stays 0 until scnt=23; transfer on that edge; s_data held stable and captured correctly; next symbol starts with no gap.
5. s_valid raised 3 cycles after a symbol ends → IDLE gap of 3 cycles with fsk_out=0; new symbol starts with fsk_out=0, hcnt=0.
6. rst_n pulsed low at scnt=10 of symbol 2 with the next symbol pending → outputs clear asynchronously; after release IDLE with s_ready=1; the pending symbol is accepted as a fresh start.
